// File: rtl/norm_sqrt_unit.sv
// Buffered integer square root of a sum of four squares: small input FIFO feeding a
// digit-by-digit root FSM. Define NORM_SQRT_ROUND_EN to round o_root to nearest.
module norm_sqrt_unit #(
  parameter int DATAWIDTH   = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int INSTANCE_ID = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_valid,
  input  logic [2*DATAWIDTH+1:0]        i_data,
  output logic                          o_valid,
  output logic [DATAWIDTH:0]            o_root,
  output logic [DATAWIDTH+1:0]          o_rem,
  output logic                          o_busy,
  output logic                          o_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int unsigned IW = 2 * DATAWIDTH + 2;
  localparam int unsigned RW = DATAWIDTH + 1;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned NW = RW + 3;
  localparam int unsigned KW = $clog2(RW + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   mem_q [FIFO_DEPTH];
  logic [IW-1:0]   mem_d [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [IW-1:0]   op_q, op_d;
  logic [NW-1:0]   rem_q, rem_d;
  logic [RW-1:0]   root_q, root_d;
  logic [KW-1:0]   iter_q, iter_d;
  logic            o_valid_q, o_valid_d;
  logic [RW-1:0]   o_root_q, o_root_d;
  logic [RW:0]     o_rem_q, o_rem_d;
  logic            busy_q, busy_d;
  logic            overflow_q, overflow_d;

  logic            pop_c, push_c, full_c;
  logic [NW-1:0]   rem_sh_c, trial_c, rem_nx_c;
  logic [RW-1:0]   root_nx_c, root_rnd_c;
  logic            unused_id_c;

  assign unused_id_c = ^32'(INSTANCE_ID);

  // FIFO control, one root digit, and the FSM.
  always_comb begin
    state_d    = state_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    op_d       = op_q;
    rem_d      = rem_q;
    root_d     = root_q;
    iter_d     = iter_q;
    o_valid_d  = 1'b0;
    o_root_d   = o_root_q;
    o_rem_d    = o_rem_q;
    overflow_d = overflow_q;

    full_c = (count_q == CW'(FIFO_DEPTH));
    pop_c  = (state_q == S_IDLE) && (count_q != '0);
    push_c = i_valid && (!full_c || pop_c);

    // Restoring step: bring down two operand bits, try subtracting 4*root+1.
    rem_sh_c = {rem_q[NW-3:0], op_q[IW-1 -: 2]};
    trial_c  = NW'({root_q, 2'b01});
    if (rem_sh_c >= trial_c) begin
      rem_nx_c  = rem_sh_c - trial_c;
      root_nx_c = {root_q[RW-2:0], 1'b1};
    end else begin
      rem_nx_c  = rem_sh_c;
      root_nx_c = {root_q[RW-2:0], 1'b0};
    end
    root_rnd_c = root_nx_c;
`ifdef NORM_SQRT_ROUND_EN
    if (rem_nx_c > NW'(root_nx_c)) root_rnd_c = root_nx_c + RW'(1);
`endif

    if (push_c) begin
      mem_d[wr_ptr_q] = i_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_c) rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(push_c) - CW'(pop_c);
    if (i_valid && !push_c) overflow_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (pop_c) begin
          op_d    = mem_q[rd_ptr_q];
          rem_d   = '0;
          root_d  = '0;
          iter_d  = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        op_d   = op_q << 2;
        rem_d  = rem_nx_c;
        root_d = root_nx_c;
        iter_d = iter_q + KW'(1);
        if (iter_q == KW'(RW - 1)) begin
          state_d   = S_DONE;
          o_valid_d = 1'b1;
          o_root_d  = root_rnd_c;
          o_rem_d   = rem_nx_c[RW:0];
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      op_q       <= '0;
      rem_q      <= '0;
      root_q     <= '0;
      iter_q     <= '0;
      o_valid_q  <= 1'b0;
      o_root_q   <= '0;
      o_rem_q    <= '0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      op_q       <= op_d;
      rem_q      <= rem_d;
      root_q     <= root_d;
      iter_q     <= iter_d;
      o_valid_q  <= o_valid_d;
      o_root_q   <= o_root_d;
      o_rem_q    <= o_rem_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  assign o_valid      = o_valid_q;
  assign o_root       = o_root_q;
  assign o_rem        = o_rem_q;
  assign o_busy       = busy_q;
  assign o_overflow   = overflow_q;
  assign o_fifo_count = count_q;

endmodule

// File: tb/tb_norm_sqrt_unit.sv
// Scoreboard bench for norm_sqrt_unit: a cycle-level queue model predicts acceptance,
// drops and result timing; a negedge monitor compares every DUT output.
module tb_norm_sqrt_unit;

  localparam int DATAWIDTH  = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int IW = 2 * DATAWIDTH + 2;
  localparam int RW = DATAWIDTH + 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_valid = 1'b0;
  logic [IW-1:0] i_data = '0;
  logic          o_valid;
  logic [RW-1:0] o_root;
  logic [RW:0]   o_rem;
  logic          o_busy;
  logic          o_overflow;
  logic [CW-1:0] o_fifo_count;

  norm_sqrt_unit #(.DATAWIDTH(DATAWIDTH), .FIFO_DEPTH(FIFO_DEPTH), .INSTANCE_ID(3)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data),
    .o_valid(o_valid), .o_root(o_root), .o_rem(o_rem), .o_busy(o_busy),
    .o_overflow(o_overflow), .o_fifo_count(o_fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct { int root; int rem; int cyc; } exp_t;

  exp_t expq[$];
  int   mq[$];
  int   cyc = 0;
  int   next_free = 0;
  int   last_pop = -100;
  bit   ovf_m = 0;
  int   exp_cnt = 0;
  bit   exp_ovf = 0;
  bit   exp_busy = 0;
  int   last_root = 0;
  int   last_rem = 0;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  function automatic exp_t model_result(input int x, input int out_cyc);
    exp_t e;
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    e.rem  = x - r * r;
    e.root = r;
`ifdef NORM_SQRT_ROUND_EN
    if (e.rem > r) e.root = r + 1;
`endif
    e.cyc = out_cyc;
    return e;
  endfunction

  // One clock cycle of stimulus; the model advances by the same cycle.
  task automatic step(input bit v, input int d);
    bit pop;
    i_valid = v;
    i_data  = IW'(d);
    exp_cnt  = mq.size();
    exp_ovf  = ovf_m;
    exp_busy = (cyc > last_pop) && (cyc <= last_pop + RW + 1);
    pop = (cyc >= next_free) && (mq.size() > 0);
    if (pop) begin
      expq.push_back(model_result(mq.pop_front(), cyc + RW + 1));
      next_free = cyc + RW + 2;
      last_pop  = cyc;
    end
    if (v) begin
      if (mq.size() < FIFO_DEPTH) mq.push_back(d);
      else ovf_m = 1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Reset for one cycle with i_valid high to show it is ignored; cycle numbering restarts.
  task automatic do_reset();
    rst = 1'b1;
    i_valid = 1'b1;
    i_data = IW'(77);
    @(posedge clk);
    #1;
    rst = 1'b0;
    i_valid = 1'b0;
    mq.delete();
    expq.delete();
    ovf_m = 0;
    next_free = 0;
    last_pop = -100;
    last_root = 0;
    last_rem = 0;
    cyc = 0;
    exp_cnt = 0;
    exp_ovf = 0;
    exp_busy = 0;
  endtask

  task automatic drain();
    int budget = 100;
    while ((expq.size() > 0 || mq.size() > 0) && budget > 0) begin
      step(0, 0);
      budget--;
    end
    chk("drain_pending", expq.size() + mq.size(), 0);
    step(0, 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (o_valid) begin
        if (expq.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("result_cycle", cyc, e.cyc);
          chk("o_root", int'(o_root), e.root);
          chk("o_rem", int'(o_rem), e.rem);
          last_root = e.root;
          last_rem  = e.rem;
        end
      end else begin
        chk("o_root_hold", int'(o_root), last_root);
        chk("o_rem_hold", int'(o_rem), last_rem);
      end
      chk("o_fifo_count", int'(o_fifo_count), exp_cnt);
      chk("o_overflow", int'(o_overflow), int'(exp_ovf));
      chk("o_busy", int'(o_busy), int'(exp_busy));
    end
  end

  initial begin
    do_reset();
    chk("reset_valid", int'(o_valid), 0);
    chk("reset_root", int'(o_root), 0);
    chk("reset_rem", int'(o_rem), 0);

    // Zero operand, then the exact/inexact/rounding corner values.
    step(1, 0);
    drain();
    do_reset();
    step(1, 900); drain();
    step(1, 10);  drain();
    step(1, 899); drain();
    step(1, 1);   drain();

    // Back-to-back burst of 1..10 against a 4-deep buffer.
    do_reset();
    for (int i = 1; i <= 10; i++) step(1, i);
    chk("burst_overflow", int'(o_overflow), 1);
    drain();

    // Reset mid-calculation aborts the operand; a new input afterwards runs normally.
    do_reset();
    step(1, 500);
    for (int i = 0; i < 3; i++) step(0, 0);
    chk("busy_before_abort", int'(o_busy), 1);
    do_reset();
    chk("abort_count", int'(o_fifo_count), 0);
    chk("abort_busy", int'(o_busy), 0);
    step(0, 0);
    step(1, 37);
    drain();

    // Randomized traffic with varying arrival density.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      int dens;
      dens = (i / 100) % 2 == 0 ? 6 : 2;
      step($urandom_range(0, dens - 1) == 0, $urandom_range(0, 900));
    end
    drain();
    step(1, $urandom_range(0, 900));
    step(1, 4 * 15 * 15);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cycle=%0d actual=running required=finished", cyc);
    $fatal(1);
  end

endmodule

// File: doc/norm_sqrt_unit.md
NORM_SQRT_UNIT -- requirements
Module: norm_sqrt_unit

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 4, giving the operand width of the upstream squarer/adder-tree; define IW = 2*DATAWIDTH+2 and RW = DATAWIDTH+1.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, giving the input buffer entries; must be a power of two and at least 2.
REQ-003 SHALL have parameter INSTANCE_ID, default 0, used only as an identifier with no functional effect.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port i_valid, input, 1 bit: i_data is valid this cycle; there is no backpressure, the producer never stalls.
REQ-007 SHALL have port i_data, input, IW bits: unsigned sum of four squares.
REQ-008 SHALL have port o_valid, output, 1 bit: one-cycle pulse marking a valid result.
REQ-009 SHALL have port o_root, output, RW bits: integer square root of the operand.
REQ-010 SHALL have port o_rem, output, RW+1 bits: operand minus floor_root squared.
REQ-011 SHALL have port o_busy, output, 1 bit: high while the FSM is not in IDLE.
REQ-012 SHALL have port o_overflow, output, 1 bit: sticky flag, set when an input is dropped.
REQ-013 SHALL have port o_fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.

Function
REQ-014 SHALL push i_data into the FIFO when i_valid=1 and either the FIFO is not full or a pop occurs in the same cycle.
REQ-015 SHALL drop i_data and set o_overflow when i_valid=1, the FIFO is full, and no pop occurs that cycle; FIFO contents are unchanged.
REQ-016 SHALL implement FSM states IDLE, CALC and DONE.
- IDLE -> CALC: when the FIFO is not empty; pop the head and load the operand.
- CALC -> DONE: after exactly RW iterations.
- DONE -> IDLE: unconditionally.
REQ-017 SHALL perform one digit-by-digit (non-restoring or restoring) root bit per CALC cycle, MSB first, using only shifts, adds and subtracts; no multipliers.
REQ-018 SHALL register o_valid=1 for exactly the DONE cycle, with o_root and o_rem valid in that cycle.
REQ-019 SHALL have latency and throughput as follows:
- Latency: i_valid at cycle t into an empty FIFO with the FSM in IDLE gives o_valid at cycle t+RW+2.
- Initiation interval: one result per RW+2 cycles.
REQ-020 SHALL hold o_root and o_rem stable between o_valid pulses.
REQ-021 SHALL emit results in input order, one per accepted input.
REQ-022 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH; a simultaneous push and pop leaves o_fifo_count unchanged.
REQ-023 SHALL guarantee o_root never overflows RW bits: the maximum input 4*(2^DATAWIDTH-1)^2 gives a root of at most 2^(DATAWIDTH+1)-2.

Reset
REQ-024 SHALL apply the following when rst=1 at a clock edge:
- FSM to IDLE and FIFO emptied.
- o_valid=0, o_root=0, o_rem=0, o_busy=0, o_overflow=0, o_fifo_count=0.
REQ-025 SHALL abort any calculation in progress when reset is asserted, with no o_valid for the aborted operand.
REQ-026 SHALL ignore i_valid during any cycle in which rst=1.

Configuration
REQ-027 SHALL use macro NORM_SQRT_ROUND_EN.
- Defined: o_root is rounded to nearest, floor_root+1 when rem > floor_root; o_rem stays the floor remainder; latency is unchanged.
- Undefined: o_root is floor_root.

Verification (DATAWIDTH=4, FIFO_DEPTH=4, so RW=5)
REQ-028 SHALL cover this case: single i_data=0 at cycle 0 -> o_valid at cycle 7 with o_root=0, o_rem=0.
REQ-029 SHALL cover this case: i_data=900 -> o_root=30, o_rem=0; i_data=10 -> o_root=3, o_rem=1, in both builds.
REQ-030 SHALL cover this case: i_data=899 -> o_rem=58, with o_root=29 without NORM_SQRT_ROUND_EN and o_root=30 with it.
REQ-031 SHALL cover this case: i_valid high for cycles 0..9 with values 1..10.
- Inputs at cycles 0-4 and 8 are accepted; inputs at cycles 5, 6, 7 and 9 are dropped.
- Exactly 6 results are emitted in order, for inputs 1, 2, 3, 4, 5 and 9.
- o_overflow=1 from cycle 6 onward.
REQ-032 SHALL cover this case: rst pulsed at cycle 4 after i_valid at cycle 0 -> no o_valid afterwards, all outputs 0, o_fifo_count=0; a new input at cycle 6 produces o_valid at cycle 13.
